// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two masters, the arbiter and the data memory.
// err_o exists only when DMEM_ARB_ALIGN_CHECK_EN is defined.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              m0_req_i;
   logic              m0_we_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [31:0]       m0_wdata_i;
   logic [31:0]       m0_rdata_o;
   logic              m0_ack_o;
   logic              m1_req_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [31:0]       m1_wdata_i;
   logic [31:0]       m1_rdata_o;
   logic              m1_ack_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_we_o;
   logic              mem_re_o;
   logic [31:0]       mem_rdata_i;
   logic              busy_o;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic              err_o;
`endif

   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
             m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
             mem_rdata_i,
      output m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o,
             mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, busy_o
`ifdef DMEM_ARB_ALIGN_CHECK_EN
             , err_o
`endif
   );

   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
             m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
             mem_rdata_i,
      input  m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o,
             mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, busy_o
`ifdef DMEM_ARB_ALIGN_CHECK_EN
             , err_o
`endif
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and fixed-latency access sequencer for the data memory.
// Optional misaligned-address rejection is compiled in with DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 32
) (
   input logic           clk_i,
   input logic           rst_i,
   dmem_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;
   localparam logic [2:0] CNT_LOAD  = 3'(LATENCY - 1);

   logic [1:0]        state_reg;
   logic [2:0]        cnt_reg;
   logic              grant_reg;
   logic              last_grant_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;

   logic [1:0]        req_vec;
   logic [1:0]        we_vec;
   logic [1:0]        ack_vec;
   logic [ADDR_W-1:0] addr_vec [2];
   logic [31:0]       wdata_vec [2];
   logic              win;
   logic              in_access;
   logic              last_beat;
   logic              rd_done;

   assign req_vec      = {bus.m1_req_i, bus.m0_req_i};
   assign we_vec       = {bus.m1_we_i, bus.m0_we_i};
   assign addr_vec[0]  = bus.m0_addr_i;
   assign addr_vec[1]  = bus.m1_addr_i;
   assign wdata_vec[0] = bus.m0_wdata_i;
   assign wdata_vec[1] = bus.m1_wdata_i;

   // On a tie the master that did not win last time gets the grant.
   always_comb begin
      if (req_vec == 2'b11) win = ~last_grant_reg;
      else                  win = req_vec[1];
   end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic err_reg;
   logic misaligned;
   assign misaligned = |addr_vec[win][1:0];
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         err_reg        <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|req_vec) begin
                  grant_reg      <= win;
                  last_grant_reg <= win;
                  we_reg         <= we_vec[win];
                  addr_reg       <= addr_vec[win];
                  wdata_reg      <= wdata_vec[win];
                  cnt_reg        <= CNT_LOAD;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                  err_reg        <= misaligned;
                  state_reg      <= misaligned ? ST_ACK : ST_ACCESS;
`else
                  state_reg      <= ST_ACCESS;
`endif
               end
            end
            ST_ACCESS: begin
               if (cnt_reg == 3'd0) state_reg <= ST_ACK;
               else                 cnt_reg   <= cnt_reg - 3'd1;
            end
            ST_ACK:  state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign in_access = (state_reg == ST_ACCESS);
   assign last_beat = in_access && (cnt_reg == 3'd0);
   assign rd_done   = last_beat && !we_reg;

   // Per-master read-data holding register and ack decode.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [31:0] rdata_reg;

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i)                           rdata_reg <= '0;
         else if (rd_done && grant_reg == 1'(gi)) rdata_reg <= bus.mem_rdata_i;
      end

      assign ack_vec[gi] = (state_reg == ST_ACK) && (grant_reg == 1'(gi));
   end

   assign bus.m0_rdata_o  = g_port[0].rdata_reg;
   assign bus.m1_rdata_o  = g_port[1].rdata_reg;
   assign bus.m0_ack_o    = ack_vec[0];
   assign bus.m1_ack_o    = ack_vec[1];

   // Memory sees only the latched request, and a write strobes on the last beat alone.
   assign bus.mem_addr_o  = in_access ? addr_reg : '0;
   assign bus.mem_wdata_o = in_access ? wdata_reg : '0;
   assign bus.mem_re_o    = in_access && !we_reg;
   assign bus.mem_we_o    = last_beat && we_reg;
   assign bus.busy_o      = (state_reg != ST_IDLE);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign bus.err_o       = (state_reg == ST_ACK) && err_reg;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LATENCY=2 instance for the main scenarios,
// LATENCY=3 instance for latency and reset-during-write checks.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   logic clk     = 1'b0;
   logic rst_i   = 1'b0;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(32)) bus2 ();
   dmem_arbiter_if #(.ADDR_W(32)) bus3 ();

   dmem_arbiter #(.LATENCY(2), .ADDR_W(32)) dut2 (.clk_i(clk), .rst_i(rst_i), .bus(bus2));
   dmem_arbiter #(.LATENCY(3), .ADDR_W(32)) dut3 (.clk_i(clk), .rst_i(rst_i), .bus(bus3));

   // Simple word memories, written on the clock edge while mem_we_o is high.
   logic [31:0] mem2 [64];
   logic [31:0] mem3 [64];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) begin
            mem2[i] <= '0;
            mem3[i] <= '0;
         end
      end else begin
         if (bus2.mem_we_o) mem2[bus2.mem_addr_o[7:2]] <= bus2.mem_wdata_o;
         if (bus3.mem_we_o) mem3[bus3.mem_addr_o[7:2]] <= bus3.mem_wdata_o;
      end
   end
   assign bus2.mem_rdata_i = mem2[bus2.mem_addr_o[7:2]];
   assign bus3.mem_rdata_i = mem3[bus3.mem_addr_o[7:2]];

   int          we_cnt2 = 0, re_cnt2 = 0, we_cnt3 = 0, ack_cnt3 = 0;
   int          ack_long = 0, ack_both = 0, rw_overlap = 0, grant_n = 0;
   int          grant_log [32];
   logic [31:0] last_we_addr2 = '0;
   logic        prev_ack0 = 1'b0, prev_ack1 = 1'b0;

   always @(negedge clk) begin
      if (bus2.mem_we_o) begin
         we_cnt2       <= we_cnt2 + 1;
         last_we_addr2 <= bus2.mem_addr_o;
      end
      if (bus2.mem_re_o) re_cnt2 <= re_cnt2 + 1;
      if (bus2.mem_re_o && bus2.mem_we_o) rw_overlap <= rw_overlap + 1;
      if (bus3.mem_we_o) we_cnt3 <= we_cnt3 + 1;
      if (bus3.m0_ack_o || bus3.m1_ack_o) ack_cnt3 <= ack_cnt3 + 1;
      if ((bus2.m0_ack_o && prev_ack0) || (bus2.m1_ack_o && prev_ack1)) ack_long <= ack_long + 1;
      if (bus2.m0_ack_o && bus2.m1_ack_o) ack_both <= ack_both + 1;
      if ((bus2.m0_ack_o || bus2.m1_ack_o) && grant_n < 32) begin
         grant_log[grant_n] <= bus2.m0_ack_o ? 0 : 1;
         grant_n            <= grant_n + 1;
      end
      prev_ack0 <= bus2.m0_ack_o;
      prev_ack1 <= bus2.m1_ack_o;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int sel, input int m, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (sel == 0 && m == 0) begin
         bus2.m0_req_i = req; bus2.m0_we_i = we; bus2.m0_addr_i = addr; bus2.m0_wdata_i = wdata;
      end else if (sel == 0) begin
         bus2.m1_req_i = req; bus2.m1_we_i = we; bus2.m1_addr_i = addr; bus2.m1_wdata_i = wdata;
      end else if (m == 0) begin
         bus3.m0_req_i = req; bus3.m0_we_i = we; bus3.m0_addr_i = addr; bus3.m0_wdata_i = wdata;
      end else begin
         bus3.m1_req_i = req; bus3.m1_we_i = we; bus3.m1_addr_i = addr; bus3.m1_wdata_i = wdata;
      end
   endtask

   function automatic logic get_ack(input int sel, input int m);
      if (sel == 0) return (m == 0) ? bus2.m0_ack_o : bus2.m1_ack_o;
      return (m == 0) ? bus3.m0_ack_o : bus3.m1_ack_o;
   endfunction

   // Counts clock edges from the request until the ack is visible.
   task automatic wait_ack(input int sel, input int m, output int edges);
      edges = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (get_ack(sel, m)) break;
      end
      check("ack_seen", {31'b0, get_ack(sel, m)}, 32'd1);
      $display("txn dut%0d m%0d: ack after %0d edges", sel, m, edges);
   endtask

   task automatic finish_txn(input int sel, input int m);
      @(posedge clk);
      #1 set_req(sel, m, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("ack_one_cycle", {31'b0, get_ack(sel, m)}, 32'd0);
   endtask

   int edges, w0, r0, g0, a0, n;

   initial begin
      for (int s = 0; s < 2; s++)
         for (int m = 0; m < 2; m++) set_req(s, m, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'b0, bus2.busy_o}, 32'd0);
      check("rst_mem_we", {31'b0, bus2.mem_we_o}, 32'd0);
      check("rst_mem_re", {31'b0, bus2.mem_re_o}, 32'd0);
      check("rst_mem_addr", bus2.mem_addr_o, 32'd0);
      check("rst_acks", {30'b0, bus2.m1_ack_o, bus2.m0_ack_o}, 32'd0);
      check("rst_m0_rdata", bus2.m0_rdata_o, 32'd0);
      @(posedge clk);
      #1 rst_i = 1'b1; mem_clr = 1'b0;
      w0 = we_cnt2; r0 = re_cnt2;
      repeat (3) @(negedge clk);
      check("idle_no_we", we_cnt2 - w0, 32'd0);
      check("idle_no_re", re_cnt2 - r0, 32'd0);
      check("idle_busy", {31'b0, bus2.busy_o}, 32'd0);

      // Master 0 write then read back
      w0 = we_cnt2; r0 = re_cnt2;
      @(posedge clk);
      #1 set_req(0, 0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
      wait_ack(0, 0, edges);
      check("wr_latency", edges, 32'd3);
      finish_txn(0, 0);
      check("wr_we_cycles", we_cnt2 - w0, 32'd1);
      check("wr_no_re", re_cnt2 - r0, 32'd0);
      check("wr_mem", mem2[2], 32'hDEADBEEF);

      r0 = re_cnt2;
      @(posedge clk);
      #1 set_req(0, 0, 1'b1, 1'b0, 32'h8, 32'h0);
      wait_ack(0, 0, edges);
      check("rd_latency", edges, 32'd3);
      check("rd_m0_data", bus2.m0_rdata_o, 32'hDEADBEEF);
      check("rd_m1_data", bus2.m1_rdata_o, 32'd0);
      finish_txn(0, 0);
      check("rd_re_cycles", re_cnt2 - r0, 32'd2);

      // Master 1 changes its address during the access
      @(posedge clk);
      #1 set_req(0, 1, 1'b1, 1'b1, 32'h4, 32'h12345678);
      @(posedge clk);
      #1 bus2.m1_addr_i = 32'hC;
      @(negedge clk);
      check("hold_addr_access", bus2.mem_addr_o, 32'h4);
      wait_ack(0, 1, edges);
      finish_txn(0, 1);
      check("hold_addr_we", last_we_addr2, 32'h4);
      check("hold_mem_4", mem2[1], 32'h12345678);
      check("hold_mem_c", mem2[3], 32'h0);

      // Both masters requesting continuously for four transactions
      g0 = grant_n;
      @(posedge clk);
      #1 set_req(0, 0, 1'b1, 1'b0, 32'h8, 32'h0);
      set_req(0, 1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge clk);
         if (bus2.m0_ack_o || bus2.m1_ack_o) n++;
      end
      @(posedge clk);
      #1 set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      check("cont_acks", n, 32'd4);
      check("cont_grants", grant_n - g0, 32'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("cont_order%0d", k), grant_log[g0 + k], k % 2);
      $display("txn contention: grants %0d %0d %0d %0d",
               grant_log[g0], grant_log[g0 + 1], grant_log[g0 + 2], grant_log[g0 + 3]);
      check("cont_m0_rdata", bus2.m0_rdata_o, 32'hDEADBEEF);
      check("cont_mem_20", mem2[8], 32'hA5A5A5A5);
      check("ack_long", ack_long, 32'd0);
      check("ack_both", ack_both, 32'd0);
      check("rw_overlap", rw_overlap, 32'd0);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
      // Misaligned read is rejected without touching memory
      r0 = re_cnt2;
      @(posedge clk);
      #1 set_req(0, 0, 1'b1, 1'b0, 32'h6, 32'h0);
      wait_ack(0, 0, edges);
      check("align_latency", edges, 32'd1);
      check("align_err", {31'b0, bus2.err_o}, 32'd1);
      finish_txn(0, 0);
      check("align_err_clear", {31'b0, bus2.err_o}, 32'd0);
      check("align_no_re", re_cnt2 - r0, 32'd0);
      check("align_rdata", bus2.m0_rdata_o, 32'hDEADBEEF);
`endif

      // LATENCY=3 instance: normal write, then reset during a write
      @(posedge clk);
      #1 set_req(1, 1, 1'b1, 1'b1, 32'h14, 32'h0BADCAFE);
      wait_ack(1, 1, edges);
      check("lat3_latency", edges, 32'd4);
      finish_txn(1, 1);
      check("lat3_mem", mem3[5], 32'h0BADCAFE);

      w0 = we_cnt3; a0 = ack_cnt3;
      @(posedge clk);
      #1 set_req(1, 0, 1'b1, 1'b1, 32'h10, 32'h55AA55AA);
      @(posedge clk);
      #1 check("mid_busy_before", {31'b0, bus3.busy_o}, 32'd1);
      rst_i = 1'b0;
      #1 check("mid_busy_rst", {31'b0, bus3.busy_o}, 32'd0);
      check("mid_we_rst", {31'b0, bus3.mem_we_o}, 32'd0);
      set_req(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_no_we", we_cnt3 - w0, 32'd0);
      check("mid_no_ack", ack_cnt3 - a0, 32'd0);
      check("mid_mem_10", mem3[4], 32'h0);
      $display("txn dut1 m0: reset during write, access abandoned");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
